divseq: RTL and testbench
=========================

Name: divseq

Overview:
- Sequential restoring divider for the 8086 DIV and IDIV instructions, byte and word forms. Performs the inverse of the combinational multiply path.
- Takes a dividend and divisor from the execution datapath. Returns remainder and quotient packed as {remainder, quotient}, in the same layout the ALU output mux uses for division.
- Flags the divide-error condition (INT 0) to the sequencer.
- The sequencer stalls on busy and consumes out/div_err when done pulses.

Parameters:
- none (widths are fixed by the package constants)

Ports:
- clk      input   1   system clock
- rst_n    input   1   asynchronous, active-low reset
- start    input   1   launch request; sampled only while busy=0
- x        input   32  dividend: word op uses DX:AX = x[31:0]; byte op uses AX = x[15:0]
- y        input   16  divisor: word op uses y[15:0]; byte op uses y[7:0]
- word_op  input   1   1 = 16-bit divide, 0 = 8-bit divide
- signed_op input  1   1 = IDIV, 0 = DIV
- busy     output  1   operation in progress
- done     output  1   one-cycle pulse; out and div_err are valid from this cycle
- out      output  32  word: {rem16, quot16}; byte: {16'd0, rem8, quot8}
- div_err  output  1   divide error (zero divisor or quotient overflow)

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; busy=0, done=0, out=0, div_err=0; all internal registers cleared. Reset mid-operation aborts the operation; no done is issued.
- Edge numbering: edge 0 is the edge that samples start=1 in IDLE. x, y, word_op and signed_op are captured at edge 0, so inputs may change afterwards. start while busy=1 is ignored.
- FSM states: IDLE, PREP, ITER, FIX.
  - IDLE -> PREP at edge 0; busy goes to 1.
  - PREP, edge 1:
    - Forms unsigned magnitudes of dividend and divisor (two's complement abs when signed_op=1).
    - Checks divisor magnitude == 0.
    - For unsigned ops only, checks high half of dividend >= divisor (word: x[31:16] >= y; byte: x[15:8] >= y[7:0]).
    - Either check true: div_err=1, out=0, done=1, busy=0, state -> IDLE.
    - Otherwise: state -> ITER, count = N-1, where N = 16 (word) or 8 (byte).
  - ITER, edges 2..N+1: one restoring step per edge.
    - Shift {partial remainder, dividend} left by one.
    - Trial subtract divisor magnitude; if the result is non-negative, keep it and set the quotient bit to 1.
    - Count decrements; at count 0 -> FIX.
  - FIX, edge N+2:
    - Quotient sign = dividend sign XOR divisor sign. Remainder takes the sign of the dividend.
    - Signed range check: quotient magnitude > 0x7FFF (word) or > 0x7F (byte) gives div_err=1, out=0.
    - Otherwise out is loaded in packed form with div_err=0.
    - done=1, busy=0, state -> IDLE.
- Latency from edge 0 to done: word 18 edges, byte 10 edges; PREP-detected error 1 edge.
- done is high for exactly one cycle. out and div_err hold their values until the next PREP/FIX load. A new start may be sampled in the done cycle (back-to-back operation).
- Intermediate arithmetic:
  - partial remainder is 17 bits (one guard bit);
  - sign fix uses 16-bit two's complement;
  - byte results are zero-extended into out[31:16].
- Unused bits of x and y in byte mode are ignored.

Optional Feature:
- DIVSEQ_RADIX4_EN defined: two restoring steps chained per ITER edge; ITER lasts N/2 edges. Latency becomes word 10, byte 6; error latency is unchanged.
- Undefined: one step per edge, as specified above.
- Results are bit-identical in both builds.

Decomposition:
- Package divseq_pkg:
  - state enum {IDLE, PREP, ITER, FIX};
  - constants WORD_ITERS=16, BYTE_ITERS=8, REM_W=17, QUOT_W=16.
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder (17), next dividend bit, divisor magnitude (16).
  - Outputs: new remainder, quotient bit.
  - Instantiated once, or twice in series under DIVSEQ_RADIX4_EN.

Test Plan:
- Word DIV, x=0x0001_0005, y=0x0002 -> out=0x0001_8002, div_err=0, done after edge 18 (10 with radix-4).
- Byte DIV, x=0x0064, y=0x0007 -> out=0x0000_020E, done after edge 10; busy=1 on edges 0..9.
- Word IDIV, x=0xFFFF_FFF9 (-7), y=0x0002 -> out=0xFFFF_FFFD (rem -1, quot -3), div_err=0.
- Zero divisor, word DIV y=0 -> div_err=1, out=0, done after edge 1; DIV x=0x0002_0000, y=0x0002 -> div_err=1 after edge 1.
- Byte IDIV, x=0x0100 (256), y=0x02 -> quotient magnitude 128 > 0x7F -> div_err=1, out=0, done after edge 10.
- Word DIV started, rst_n=0 at edge 5 -> busy=0, done=0, out=0, no done pulse. start=1 pulsed while busy -> ignored, result unaffected. New start in the done cycle -> accepted.

Source files
------------

// File: rtl/divseq_pkg.sv
// divseq_pkg: shared types, widths and small helpers for the sequential divider.
// Optional build macro DIVSEQ_RADIX4_EN selects two restoring steps per iteration edge.
package divseq_pkg;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  localparam int WORD_ITERS = 16;
  localparam int BYTE_ITERS = 8;
  localparam int REM_W      = 17;
  localparam int QUOT_W     = 16;

`ifdef DIVSEQ_RADIX4_EN
  localparam int STEPS_PER_EDGE = 2;
`else
  localparam int STEPS_PER_EDGE = 1;
`endif

  // Initial down-counter value: number of iteration edges minus one.
  function automatic logic [3:0] iter_count(input logic word_op);
    if (word_op) return 4'(WORD_ITERS / STEPS_PER_EDGE - 1);
    return 4'(BYTE_ITERS / STEPS_PER_EDGE - 1);
  endfunction

  // 16-bit two's complement negate when neg is set.
  function automatic logic [15:0] neg_if(input logic neg, input logic [15:0] v);
    return neg ? 16'(-v) : v;
  endfunction

endpackage

// File: rtl/divseq_if.sv
// divseq_if: launch/result bundle between the execution sequencer and the divider.
interface divseq_if;
  import divseq_pkg::*;

  logic              start;
  logic [31:0]       x;
  logic [QUOT_W-1:0] y;
  logic              word_op;
  logic              signed_op;
  logic              busy;
  logic              done;
  logic [31:0]       out;
  logic              div_err;

  modport master (output start, x, y, word_op, signed_op,
                  input  busy, done, out, div_err);
  modport slave  (input  start, x, y, word_op, signed_op,
                  output busy, done, out, div_err);
endinterface

// File: rtl/divseq_div_step.sv
// div_step: one combinational restoring-division step on a 17-bit partial remainder.
module div_step
  import divseq_pkg::*;
(
  input  logic [REM_W-1:0]  i_rem,
  input  logic              i_bit,
  input  logic [QUOT_W-1:0] i_dmag,
  output logic [REM_W-1:0]  o_rem,
  output logic              o_qbit
);
  logic [REM_W-1:0] w_shift;
  logic [REM_W:0]   w_diff;

  assign w_shift = {i_rem[REM_W-2:0], i_bit};
  // Trial subtract; the extra top bit is the borrow.
  assign w_diff  = {1'b0, w_shift} - {2'b00, i_dmag};
  assign o_qbit  = ~w_diff[REM_W];
  assign o_rem   = o_qbit ? w_diff[REM_W-1:0] : w_shift;
endmodule

// File: rtl/divseq.sv
// divseq: sequential restoring divider for 8086 DIV/IDIV (byte and word forms).
// Build macro DIVSEQ_RADIX4_EN chains two div_step instances per ITER edge.
module divseq
  import divseq_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  divseq_if.slave  bus
);
  state_t            r_state, w_next;
  logic [31:0]       r_x, r_out;
  logic [15:0]       r_y;
  logic              r_word, r_signed;
  logic [REM_W-1:0]  r_rem;
  logic [QUOT_W-1:0] r_quot, r_dmag;
  logic [3:0]        r_count;
  logic              r_qneg, r_rneg, r_ovf;
  logic              r_busy, r_done, r_err;

  logic              w_xsign, w_ysign, w_prep_err, w_fix_err;
  logic [31:0]       w_xmag, w_fix_out;
  logic [15:0]       w_ymag, w_xhi, w_xlo, w_qmag, w_rmag, w_qval, w_rval;
  logic [REM_W-1:0]  w_rem0, w_step_rem;
  logic [QUOT_W-1:0] w_step_quot;
  logic              w_q0;

  // Operand signs only matter for IDIV.
  assign w_xsign = r_signed & (r_word ? r_x[31] : r_x[15]);
  assign w_ysign = r_signed & (r_word ? r_y[15] : r_y[7]);

  // Unsigned magnitudes of the captured dividend and divisor.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_xmag = {16'd0, r_x[15:0]};
    w_ymag = {8'd0, r_y[7:0]};
    if (r_word) begin
      w_xmag = r_x;
      w_ymag = r_y;
    end
    if (w_xsign) w_xmag = r_word ? 32'(-r_x) : {16'd0, 16'(-r_x[15:0])};
    if (w_ysign) w_ymag = r_word ? 16'(-r_y) : {8'd0, 8'(-r_y[7:0])};
  end

  // High half seeds the partial remainder; low half is shifted in MSB first.
  assign w_xhi      = r_word ? w_xmag[31:16] : {8'd0, w_xmag[15:8]};
  assign w_xlo      = r_word ? w_xmag[15:0]  : {w_xmag[7:0], 8'd0};
  assign w_prep_err = (w_ymag == 16'd0) || (!r_signed && (w_xhi >= w_ymag));

  div_step u_step0 (
    .i_rem  (r_rem),
    .i_bit  (r_quot[QUOT_W-1]),
    .i_dmag (r_dmag),
    .o_rem  (w_rem0),
    .o_qbit (w_q0)
  );

`ifdef DIVSEQ_RADIX4_EN
  logic [REM_W-1:0] w_rem1;
  logic             w_q1;

  div_step u_step1 (
    .i_rem  (w_rem0),
    .i_bit  (r_quot[QUOT_W-2]),
    .i_dmag (r_dmag),
    .o_rem  (w_rem1),
    .o_qbit (w_q1)
  );

  assign w_step_rem  = w_rem1;
  assign w_step_quot = {r_quot[QUOT_W-3:0], w_q0, w_q1};
`else
  assign w_step_rem  = w_rem0;
  assign w_step_quot = {r_quot[QUOT_W-2:0], w_q0};
`endif

  // Sign fix-up and signed range check on the finished magnitudes.
  assign w_qmag    = r_word ? r_quot : {8'd0, r_quot[7:0]};
  assign w_rmag    = r_word ? r_rem[15:0] : {8'd0, r_rem[7:0]};
  assign w_qval    = neg_if(r_qneg, w_qmag);
  assign w_rval    = neg_if(r_rneg, w_rmag);
  assign w_fix_err = r_signed & (r_ovf | (w_qmag > (r_word ? 16'h7FFF : 16'h007F)));
  assign w_fix_out = r_word ? {w_rval, w_qval} : {16'd0, w_rval[7:0], w_qval[7:0]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = PREP;
      PREP:    w_next = w_prep_err ? IDLE : ITER;
      ITER:    if (r_count == 4'd0) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture, prepare, iterate, and load results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0; r_y <= '0; r_word <= 1'b0; r_signed <= 1'b0;
      r_rem <= '0; r_quot <= '0; r_dmag <= '0; r_count <= '0;
      r_qneg <= 1'b0; r_rneg <= 1'b0; r_ovf <= 1'b0;
      r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0; r_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_x      <= bus.x;
          r_y      <= bus.y;
          r_word   <= bus.word_op;
          r_signed <= bus.signed_op;
          r_busy   <= 1'b1;
        end
        PREP: if (w_prep_err) begin
          r_err  <= 1'b1;
          r_out  <= '0;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end else begin
          r_rem   <= {1'b0, w_xhi};
          r_quot  <= w_xlo;
          r_dmag  <= w_ymag;
          r_count <= iter_count(r_word);
          r_qneg  <= w_xsign ^ w_ysign;
          r_rneg  <= w_xsign;
          // Signed quotient cannot fit when the high half already reaches the divisor.
          r_ovf   <= (w_xhi >= w_ymag);
        end
        ITER: begin
          r_rem   <= w_step_rem;
          r_quot  <= w_step_quot;
          r_count <= r_count - 4'd1;
        end
        FIX: begin
          r_err  <= w_fix_err;
          r_out  <= w_fix_err ? 32'd0 : w_fix_out;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.out     = r_out;
  assign bus.div_err = r_err;
endmodule

// File: tb/tb_divseq.sv
// tb_divseq: directed bench for divseq with an arithmetic reference model and per-cycle compare.
module tb_divseq;
  import divseq_pkg::*;

`ifdef DIVSEQ_RADIX4_EN
  localparam int FULL_WORD = 10;
  localparam int FULL_BYTE = 6;
`else
  localparam int FULL_WORD = 18;
  localparam int FULL_BYTE = 10;
`endif

  typedef struct {
    logic        err;
    logic [31:0] out;
    int          lat;
    int          done_edge;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   edge_no = 0;
  bit   chk_en  = 1'b0;
  exp_t pend[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  divseq_if bus();
  divseq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: 8086 DIV/IDIV semantics from plain integer arithmetic.
  function automatic exp_t model(input logic [31:0] x, input logic [15:0] y,
                                 input logic w, input logic s);
    exp_t   e;
    longint dd, dv, q, r, qmax;
    e.err = 1'b0; e.out = '0; e.done_edge = 0;
    e.lat = w ? FULL_WORD : FULL_BYTE;
    if (w) begin
      if (s) begin dd = longint'($signed(x)); dv = longint'($signed(y)); qmax = 32767; end
      else   begin dd = longint'(x);          dv = longint'(y);          qmax = 65535; end
    end else begin
      if (s) begin dd = longint'($signed(x[15:0])); dv = longint'($signed(y[7:0])); qmax = 127; end
      else   begin dd = longint'(x[15:0]);          dv = longint'(y[7:0]);          qmax = 255; end
    end
    if (dv == 0) begin
      e.err = 1'b1; e.lat = 1;
      return e;
    end
    q = dd / dv;
    r = dd % dv;
    if (!s && q > qmax) begin
      e.err = 1'b1; e.lat = 1;
    end else if (s && (q > qmax || q < -qmax)) begin
      e.err = 1'b1;
    end else begin
      e.out = w ? {r[15:0], q[15:0]} : {16'd0, r[7:0], q[7:0]};
    end
    return e;
  endfunction

  // Compare process: every cycle, done/busy and (on done) the result.
  always @(negedge clk) begin
    if (chk_en) begin
      if (pend.size() > 0 && edge_no == pend[0].done_edge) begin
        check("done", 64'(bus.done), 64'd1);
        check("out", 64'(bus.out), 64'(pend[0].out));
        check("div_err", 64'(bus.div_err), 64'(pend[0].err));
        check("busy_at_done", 64'(bus.busy), 64'd0);
        void'(pend.pop_front());
      end else if (pend.size() > 0 && edge_no > pend[0].done_edge) begin
        total++; bad++;
        $display("FAIL missed_done: no done at edge %0d", pend[0].done_edge);
        void'(pend.pop_front());
      end else begin
        check("done_idle", 64'(bus.done), 64'd0);
        check("busy", 64'(bus.busy), (pend.size() > 0) ? 64'd1 : 64'd0);
      end
    end
  end

  // Launch one operation as soon as busy is low; scramble inputs after capture.
  task automatic issue(input logic [31:0] x, input logic [15:0] y, input logic w, input logic s);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      total++; bad++;
      $display("FAIL issue_wait: busy stuck high");
    end
    bus.start = 1'b1; bus.x = x; bus.y = y; bus.word_op = w; bus.signed_op = s;
    e = model(x, y, w, s);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x = $urandom; bus.y = 16'($urandom);
    bus.word_op = 1'($urandom); bus.signed_op = 1'($urandom);
    e.done_edge = edge_no + e.lat;
    pend.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pend.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (pend.size() > 0) begin
      total++; bad++;
      $display("FAIL wait_idle: %0d operations never completed", pend.size());
      pend.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.word_op = 1'b0; bus.signed_op = 1'b0;

    // Pin the model to hand-computed results.
    m = model(32'h0001_0005, 16'h0002, 1'b1, 1'b0);
    check("pin_wdiv_out", 64'(m.out), 64'h0001_8002);
    check("pin_wdiv_lat", 64'(m.lat), 64'(FULL_WORD));
    m = model(32'h0000_0064, 16'h0007, 1'b0, 1'b0);
    check("pin_bdiv_out", 64'(m.out), 64'h0000_020E);
    m = model(32'hFFFF_FFF9, 16'h0002, 1'b1, 1'b1);
    check("pin_widiv_out", 64'(m.out), 64'hFFFF_FFFD);
    m = model(32'h0002_0000, 16'h0002, 1'b1, 1'b0);
    check("pin_wovf_err", 64'({m.err, 8'(m.lat)}), 64'h101);
    m = model(32'h0000_0100, 16'h0002, 1'b0, 1'b1);
    check("pin_bidiv_ovf", 64'({m.err, 8'(m.lat), m.out}), {23'd0, 1'b1, 8'(FULL_BYTE), 32'd0});

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_err", 64'(bus.div_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Directed vectors, launched back to back (next start in the done cycle).
    issue(32'h0001_0005, 16'h0002, 1'b1, 1'b0);
    issue(32'hABCD_0064, 16'h5507, 1'b0, 1'b0);   // byte DIV, junk upper bits
    issue(32'hFFFF_FFF9, 16'h0002, 1'b1, 1'b1);
    issue(32'h1234_5678, 16'h0000, 1'b1, 1'b0);   // zero divisor
    issue(32'h0002_0000, 16'h0002, 1'b1, 1'b0);   // unsigned overflow
    issue(32'h0000_0100, 16'h0002, 1'b0, 1'b1);   // byte IDIV quotient 128
    issue(32'hFFFE_FFFF, 16'hFFFF, 1'b1, 1'b0);   // max word quotient
    issue(32'h0000_0064, 16'hFFF9, 1'b1, 1'b1);   // 100 / -7
    issue(32'h0000_FF9C, 16'h0007, 1'b0, 1'b1);   // -100 / 7 byte
    issue(32'h0000_8000, 16'h0001, 1'b1, 1'b1);   // +32768 overflow at FIX
    issue(32'hFFFF_8001, 16'h0001, 1'b1, 1'b1);   // -32767 fits
    issue(32'h0000_7F00, 16'h0001, 1'b0, 1'b1);   // byte IDIV large overflow
    issue(32'h0000_00FF, 16'hFF00, 1'b0, 1'b0);   // byte zero divisor, junk high y
    issue(32'h0000_0700, 16'h0007, 1'b0, 1'b0);   // byte high half == divisor
    issue(32'h0000_0005, 16'hFFFF, 1'b1, 1'b1);   // 5 / -1
    issue(32'h0000_0100, 16'h0080, 1'b0, 1'b1);   // 256 / -128
    wait_idle();

    // start pulses while busy are ignored.
    issue(32'h0000_00C8, 16'h000D, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.x = 32'h0000_0000; bus.y = 16'h0000; bus.word_op = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset mid-operation: aborted, no done.
    issue(32'h0003_0007, 16'h0005, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    pend.delete();
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_out", 64'(bus.out), 64'd0);
    check("abort_err", 64'(bus.div_err), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 64'(bus.done), 64'd0);
    end
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // Random operations against the model.
    for (int i = 0; i < 20; i++)
      issue($urandom, 16'($urandom_range(0, 65535) >> $urandom_range(0, 15)),
            1'($urandom), 1'($urandom));
    wait_idle();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
